unsigned_multiply_add_16_bit: RTL and testbench

Sequential radix-2 shift-add unit that computes product = MULTIPLICAND × MULTIPLIER + ADDEND for unsigned operands. It is the inverse companion of the 16-bit unsigned divider. Feeding it quotient, divisor and remainder rebuilds the dividend, so it serves both as a general multiplier and as the divider's result checker. It uses the same start / output_ready / Error handshake style as the divider.

---
 rtl/unsigned_arith_pkg.sv | 12 +
 rtl/unsigned_multiply_add_16_bit_if.sv | 23 ++
 rtl/unsigned_multiply_add_16_bit_shift_add.sv | 17 +
 rtl/unsigned_multiply_add_16_bit.sv | 94 +++++++++
 tb/tb_unsigned_multiply_add_16_bit.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/unsigned_arith_pkg.sv
// Shared definitions for the 16-bit unsigned arithmetic blocks
// (multiply-add and its divider companion).
package unsigned_arith_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int CNT_W      = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/unsigned_multiply_add_16_bit_if.sv
// Request/response bundle for the multiply-add unit.
// The master side drives the operands and start; the slave side (the unit) returns the result.
interface unsigned_multiply_add_16_bit_if #(
  parameter int DATA_WIDTH = 16
);
  logic                      start_multiplication;
  logic [DATA_WIDTH-1:0]     MULTIPLICAND;
  logic [DATA_WIDTH-1:0]     MULTIPLIER;
  logic [DATA_WIDTH-1:0]     ADDEND;
  logic [2*DATA_WIDTH-1:0]   product;
  logic                      output_ready;
  logic                      Error;

  modport master (
    output start_multiplication, MULTIPLICAND, MULTIPLIER, ADDEND,
    input  product, output_ready, Error
  );

  modport slave (
    input  start_multiplication, MULTIPLICAND, MULTIPLIER, ADDEND,
    output product, output_ready, Error
  );
endinterface

// File: rtl/unsigned_multiply_add_16_bit_shift_add.sv
// One radix-2 shift-add iteration.
// Conditionally add A into the upper half of P, then shift the whole accumulator right by one.
module shift_add_step #(
  parameter int W = 16
) (
  input  logic [2*W:0]  p_in,
  input  logic [W-1:0]  a,
  output logic [2*W:0]  p_out
);
  logic [W:0] upper;

  // P[2W] is always 0 going in, so the W+1 bit sum cannot overflow.
  always_comb begin
    upper = p_in[2*W:W] + (p_in[0] ? {1'b0, a} : '0);
    p_out = {1'b0, upper, p_in[W-1:1]};
  end
endmodule

// File: rtl/unsigned_multiply_add_16_bit.sv
// Sequential radix-2 unsigned multiply-add: product = MULTIPLICAND * MULTIPLIER + ADDEND.
// The latency is fixed at DATA_WIDTH iterations.
// Optional range flag: UNSIGNED_MUL_RANGE_CHECK_EN. When it is defined, Error flags a result that
// does not fit in DATA_WIDTH bits. When it is undefined, Error is tied to 0.
module unsigned_multiply_add_16_bit
  import unsigned_arith_pkg::*;
(
  input  logic                         Clk,
  input  logic                         reset_n,
  unsigned_multiply_add_16_bit_if.slave bus
);
  localparam int W = DATA_WIDTH;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       a_q;
  logic [2*W:0]       p_q, p_nxt;
  logic [2*W-1:0]     product_q;
  logic               last_iter;

  assign last_iter = (cnt == CNT_W'(W - 1));

  shift_add_step #(.W(W)) u_step (
    .p_in  (p_q),
    .a     (a_q),
    .p_out (p_nxt)
  );

  // State register
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a held start keeps DONE so one request yields one operation
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_multiplication)  state_nxt = CALC;
      CALC:    if (last_iter)                 state_nxt = DONE;
      DONE:    if (!bus.start_multiplication) state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands in IDLE, iterate in CALC, latch the result on the last step
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      a_q       <= '0;
      p_q       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_multiplication) begin
          a_q <= bus.MULTIPLICAND;
          p_q <= {1'b0, bus.ADDEND, bus.MULTIPLIER};
          cnt <= '0;
        end
        CALC: begin
          p_q <= p_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) product_q <= p_nxt[2*W-1:0];
        end
        default: ;
      endcase
    end
  end

`ifdef UNSIGNED_MUL_RANGE_CHECK_EN
  logic err_q;

  // Range flag: set with the result when the upper half is non-zero, cleared when DONE is left
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (state == CALC && last_iter)
      err_q <= |p_nxt[2*W-1:W];
    else if (state == DONE && !bus.start_multiplication)
      err_q <= 1'b0;
  end
`endif

  // Output logic
  always_comb begin
    bus.product      = product_q;
    bus.output_ready = (state == DONE);
`ifdef UNSIGNED_MUL_RANGE_CHECK_EN
    bus.Error        = err_q;
`else
    bus.Error        = 1'b0;
`endif
  end
endmodule

// File: tb/tb_unsigned_multiply_add_16_bit.sv
// Directed, table-driven bench for unsigned_multiply_add_16_bit.
// Expected Error values follow UNSIGNED_MUL_RANGE_CHECK_EN.
module tb_unsigned_multiply_add_16_bit;
  logic Clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  unsigned_multiply_add_16_bit_if #(.DATA_WIDTH(16)) bus ();

  unsigned_multiply_add_16_bit dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] a, b, c;
    logic [31:0] p;
    logic        err_rc;   // Error expected when the range check is built in
  } vec_t;

  vec_t vecs [8];

  function automatic logic exp_err(input logic e);
`ifdef UNSIGNED_MUL_RANGE_CHECK_EN
    return e;
`else
    return 1'b0 & e;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left #1 after a posedge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic [15:0] a, b, c,
                        input logic [31:0] p, input logic e, input int hold);
    int cyc;
    bus.MULTIPLICAND = a;
    bus.MULTIPLIER   = b;
    bus.ADDEND       = c;
    bus.start_multiplication = 1'b1;
    @(posedge Clk); #1;            // capture edge
    cyc = 0;
    while (!bus.output_ready && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd16);
    check({tag, " ready"},   {31'd0, bus.output_ready}, 32'd1);
    check({tag, " product"}, bus.product, p);
    check({tag, " error"},   {31'd0, bus.Error}, {31'd0, exp_err(e)});
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      check({tag, " hold ready"},   {31'd0, bus.output_ready}, 32'd1);
      check({tag, " hold product"}, bus.product, p);
    end
    bus.start_multiplication = 1'b0;
    @(posedge Clk); #1;
    check({tag, " idle ready"},   {31'd0, bus.output_ready}, 32'd0);
    check({tag, " idle error"},   {31'd0, bus.Error}, 32'd0);
    check({tag, " idle product"}, bus.product, p);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{16'h0003, 16'h1234, 16'h0005, 32'h0000_36A1, 1'b0};
    vecs[1] = '{16'h0000, 16'hD84B, 16'h79E4, 32'h0000_79E4, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, 1'b1};
    vecs[3] = '{16'h0100, 16'h0100, 16'h0000, 32'h0001_0000, 1'b1};
    vecs[4] = '{16'h00FF, 16'h0101, 16'h0000, 32'h0000_FFFF, 1'b0};
    vecs[5] = '{16'h1234, 16'h5678, 16'h9ABC, 32'h0626_9B1C, 1'b1};
    vecs[6] = '{16'hFFFF, 16'h0001, 16'h0000, 32'h0000_FFFF, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0};

    bus.start_multiplication = 1'b0;
    bus.MULTIPLICAND = '0;
    bus.MULTIPLIER   = '0;
    bus.ADDEND       = '0;

    // Reset, then stay idle
    #25;
    check("reset product", bus.product, 32'd0);
    check("reset ready",   {31'd0, bus.output_ready}, 32'd0);
    check("reset error",   {31'd0, bus.Error}, 32'd0);
    #2 reset_n = 1'b1;
    repeat (4) begin
      @(posedge Clk); #1;
      check("idle ready", {31'd0, bus.output_ready}, 32'd0);
    end
    check("idle product", bus.product, 32'd0);

    // First vector holds start for several cycles in DONE: one operation only
    run_op("basic", vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].p, vecs[0].err_rc, 6);
    for (int i = 1; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].p, vecs[i].err_rc, 1);

    // Operands changed and start dropped during CALC
    bus.MULTIPLICAND = 16'h0003;
    bus.MULTIPLIER   = 16'h1234;
    bus.ADDEND       = 16'h0005;
    bus.start_multiplication = 1'b1;
    @(posedge Clk); #1;
    bus.MULTIPLICAND = 16'hFFFF;
    bus.MULTIPLIER   = 16'hFFFF;
    bus.ADDEND       = 16'hFFFF;
    bus.start_multiplication = 1'b0;
    cyc = 0;
    while (!bus.output_ready && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    check("midchg latency", 32'(cyc), 32'd16);
    check("midchg product", bus.product, 32'h0000_36A1);
    check("midchg error",   {31'd0, bus.Error}, 32'd0);
    @(posedge Clk); #1;
    check("midchg idle ready", {31'd0, bus.output_ready}, 32'd0);

    // Reset pulsed at iteration 8 aborts the operation
    bus.MULTIPLICAND = 16'h1234;
    bus.MULTIPLIER   = 16'h5678;
    bus.ADDEND       = 16'h9ABC;
    bus.start_multiplication = 1'b1;
    @(posedge Clk); #1;
    repeat (8) @(posedge Clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort product", bus.product, 32'd0);
    check("abort ready",   {31'd0, bus.output_ready}, 32'd0);
    check("abort error",   {31'd0, bus.Error}, 32'd0);
    bus.start_multiplication = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge Clk); #1;
    check("post-abort ready", {31'd0, bus.output_ready}, 32'd0);
    run_op("post-abort", 16'h00FF, 16'h0101, 16'h0000, 32'h0000_FFFF, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog against a hung DUT
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
